// File: rtl/systolic_lane_array.sv
// Linear systolic pipeline of DEPTH stages by LANES lanes with stationary
// per-stage coefficients, per-token ALU mode tags and valid/ready flow control.
module systolic_lane_array #(
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*W-1:0]           in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*W-1:0]           out_data,
    input  logic                         cfg_we,
    input  logic [W-1:0]                 cfg_data,
    output logic                         cfg_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int OW = $clog2(DEPTH+1);
    localparam int DW = LANES * W;

    localparam logic [1:0] OP_PASS = 2'd0;
    localparam logic [1:0] OP_WRAP = 2'd1;
    localparam logic [1:0] OP_SAT  = 2'd2;
    localparam logic [1:0] OP_MIN  = 2'd3;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_STREAM,
        S_FULL
    } state_t;

    state_t                      state_q, state_d;
    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0][DW-1:0]    d_q, d_d;
    logic [DEPTH-1:0][1:0]       m_q, m_d;
    logic [DEPTH-1:0][W-1:0]     c_q, c_d;
    logic [OW-1:0]               occ_q, occ_d;

    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0][DW-1:0]    src_d;
    logic [DEPTH-1:0][1:0]       src_m;

    logic adv;
    logic cfg_load;
    logic accept;
    logic consume;

    function automatic logic [W-1:0] alu(
        input logic [1:0]   op,
        input logic [W-1:0] x,
        input logic [W-1:0] c
    );
        logic [W:0] sum;
        sum = {1'b0, x} + {1'b0, c};
        case (op)
            OP_PASS: alu = x;
            OP_WRAP: alu = sum[W-1:0];
            OP_SAT:  alu = sum[W] ? {W{1'b1}} : sum[W-1:0];
            OP_MIN:  alu = (x < c) ? x : c;
            default: alu = x;
        endcase
    endfunction

    assign cfg_ready = (state_q == S_EMPTY);
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occ       = occ_q;

    // Global stall, handshakes and config-over-input priority.
    always_comb begin
        adv      = !v_q[DEPTH-1] || out_ready;
        cfg_load = cfg_we && cfg_ready;
        in_ready = adv && !cfg_load;
        accept   = in_valid && in_ready;
        consume  = v_q[DEPTH-1] && out_ready;
    end

    // Each stage's operand source: stage 0 takes the input port.
    always_comb begin
        src_v = {v_q[DEPTH-2:0], accept};
        src_d = {d_q[DEPTH-2:0], in_data};
        src_m = {m_q[DEPTH-2:0], mode};
    end

    // Advance every stage together; bubbles keep their old data.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        m_d = m_q;
        if (adv) begin
            v_d = src_v;
            for (int s = 0; s < DEPTH; s++) begin
                if (src_v[s]) begin
                    m_d[s] = src_m[s];
                    for (int k = 0; k < LANES; k++) begin
                        d_d[s][k*W +: W] =
                            alu(src_m[s], src_d[s][k*W +: W], c_q[s]);
                    end
                end
            end
        end
    end

    // Serial coefficient shift-in, only while the pipeline is empty.
    always_comb begin
        c_d = c_q;
        if (cfg_load) begin
            c_d = {c_q[DEPTH-2:0], cfg_data};
        end
    end

    // Occupancy and the occupancy-derived control state.
    always_comb begin
        occ_d   = occ_q + OW'(accept) - OW'(consume);
        state_d = S_STREAM;
        if (occ_d == '0) begin
            state_d = S_EMPTY;
        end else if (occ_d == OW'(DEPTH)) begin
            state_d = S_FULL;
        end
    end

    // All state registers; reset drops every token and coefficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            v_q     <= '0;
            d_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            d_q     <= d_d;
            m_q     <= m_d;
            c_q     <= c_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_systolic_lane_array.sv
// Scoreboard bench for systolic_lane_array (LANES=4, DEPTH=4, W=4):
// directed scenarios followed by a randomized handshake phase.
module tb_systolic_lane_array;

    logic        clk = 0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        cfg_we;
    logic [3:0]  cfg_data;
    logic        cfg_ready;
    logic [2:0]  occ;

    int checks   = 0;
    int failures = 0;
    int cm[4];
    logic [15:0] expq[$];

    systolic_lane_array #(.LANES(4), .DEPTH(4), .W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-pipeline result: sum / min over all coefficients.
    function automatic logic [15:0] model(input logic [1:0] md,
                                          input logic [15:0] x);
        int sum, mn, xi, r;
        logic [15:0] res;
        sum = cm[0] + cm[1] + cm[2] + cm[3];
        mn = cm[0];
        for (int s = 1; s < 4; s++) if (cm[s] < mn) mn = cm[s];
        res = '0;
        for (int k = 0; k < 4; k++) begin
            xi = int'(x[k*4 +: 4]);
            case (md)
                2'd0: r = xi;
                2'd1: r = (xi + sum) % 16;
                2'd2: r = (xi + sum > 15) ? 15 : xi + sum;
                default: r = (xi < mn) ? xi : mn;
            endcase
            res[k*4 +: 4] = 4'(r);
        end
        return res;
    endfunction

    task automatic cfg_model(input logic [3:0] v);
        cm[3] = cm[2];
        cm[2] = cm[1];
        cm[1] = cm[0];
        cm[0] = int'(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] md, input logic [15:0] dt);
        bit ok;
        ok = 0;
        in_valid = 1;
        mode = md;
        in_data = dt;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                expq.push_back(model(md, dt));
            end
            tick();
        end
        in_valid = 0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic cfg_write(input logic [3:0] v);
        cfg_we = 1;
        cfg_data = v;
        @(negedge clk);
        if (cfg_ready) cfg_model(v);
        tick();
        cfg_we = 0;
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 60 && occ != 0; n++) tick();
        check("drain_occ", 32'(occ), 0);
    endtask

    // Monitor: pops expected data whenever an output token is consumed.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("out_data", 32'(out_data), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] first;
        int m_occ;
        bit exp_ir, acc, con;

        rst_n = 0; mode = 0; in_valid = 0; in_data = 0;
        out_ready = 1; cfg_we = 0; cfg_data = 0;
        for (int s = 0; s < 4; s++) cm[s] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();

        // Reset idle state.
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_occ", 32'(occ), 0);

        // Coefficients 1,2,3,4 and exact latency.
        cfg_write(4'd1);
        cfg_write(4'd2);
        cfg_write(4'd3);
        cfg_write(4'd4);
        send(2'd1, 16'h3333);
        tick();
        tick();
        check("lat_not_yet", 32'(out_valid), 0);
        tick();
        check("lat_valid", 32'(out_valid), 1);
        check("lat_data", 32'(out_data), 32'hDDDD);
        send(2'd1, 16'h9999);
        send(2'd2, 16'h9999);
        send(2'd3, 16'hF0F8);
        wait_empty();

        // Back-to-back tokens give back-to-back outputs.
        send(2'd0, 16'h5555);
        send(2'd1, 16'h5555);
        tick();
        tick();
        check("b2b_v0", 32'(out_valid), 1);
        check("b2b_d0", 32'(out_data), 32'h5555);
        tick();
        check("b2b_v1", 32'(out_valid), 1);
        check("b2b_d1", 32'(out_data), 32'hFFFF);
        wait_empty();

        // Full stall, frozen output, accept+consume at full.
        out_ready = 0;
        send(2'd0, 16'h1234);
        send(2'd1, 16'h0F0F);
        send(2'd2, 16'hEDCB);
        send(2'd3, 16'h7A3C);
        first = model(2'd0, 16'h1234);
        check("full_occ", 32'(occ), 4);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_out_valid", 32'(out_valid), 1);
        check("full_data", 32'(out_data), 32'(first));
        tick();
        tick();
        check("frozen_data", 32'(out_data), 32'(first));
        check("frozen_occ", 32'(occ), 4);
        out_ready = 1;
        send(2'd1, 16'h2468);
        check("acc_con_occ", 32'(occ), 4);
        for (int k = 3; k >= 0; k--) begin
            tick();
            check("drain_count", 32'(occ), 32'(k));
        end

        // Config ignored while occupied; config beats input when empty.
        out_ready = 0;
        send(2'd1, 16'h1111);
        send(2'd3, 16'hF0F8);
        check("occ2", 32'(occ), 2);
        cfg_we = 1;
        cfg_data = 4'h7;
        @(negedge clk);
        check("cfg_blocked", 32'(cfg_ready), 0);
        tick();
        cfg_we = 0;
        check("occ2_hold", 32'(occ), 2);
        out_ready = 1;
        wait_empty();
        cfg_we = 1;
        cfg_data = 4'h7;
        in_valid = 1;
        mode = 2'd1;
        in_data = 16'hABCD;
        @(negedge clk);
        check("cfg_prio_in_ready", 32'(in_ready), 0);
        check("cfg_prio_cfg_ready", 32'(cfg_ready), 1);
        if (cfg_ready) cfg_model(4'h7);
        tick();
        cfg_we = 0;
        in_valid = 0;
        check("cfg_prio_occ", 32'(occ), 0);
        send(2'd1, 16'h1234);
        send(2'd3, 16'hF0F8);
        wait_empty();

        // Mid-stream reset drops tokens and coefficients.
        out_ready = 0;
        send(2'd1, 16'h1357);
        send(2'd2, 16'h2468);
        send(2'd0, 16'h9BDF);
        check("pre_rst_occ", 32'(occ), 3);
        rst_n = 0;
        #1;
        check("mid_rst_occ", 32'(occ), 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_cfg_ready", 32'(cfg_ready), 1);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        expq.delete();
        for (int s = 0; s < 4; s++) cm[s] = 0;
        tick();
        rst_n = 1;
        out_ready = 1;
        send(2'd1, 16'h3333);
        send(2'd2, 16'hABCD);
        wait_empty();

        // Randomized handshakes with occupancy model.
        m_occ = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 1) == 0);
            mode = 2'($urandom);
            in_data = 16'($urandom);
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_data = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("rnd_occ", 32'(occ), 32'(m_occ));
            check("rnd_cfg_ready", 32'(cfg_ready), 32'(m_occ == 0));
            exp_ir = (!out_valid || out_ready) && !(cfg_we && m_occ == 0);
            check("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
            if (cfg_we && m_occ == 0) cfg_model(cfg_data);
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (acc) expq.push_back(model(mode, in_data));
            m_occ = m_occ + int'(acc) - int'(con);
            tick();
        end
        in_valid = 0;
        cfg_we = 0;
        out_ready = 1;
        wait_empty();
        tick();
        check("queue_empty", 32'(expq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
